vga_timing_gen: RTL and testbench

Parametrised single-clock VGA raster timing generator, the successor to the fixed 640x480 sync block. Both counters run in the CLK domain: the vertical counter advances on horizontal wrap, not on the HSYNC edge. Adds:
- a clock-enable for pixel-rate division;
- configurable sync polarity;
- data-enable and line/frame start strobes;
- a programmable pipeline delay, so that sync/DE line up with pixel data fetched from downstream memory using O_X/O_Y.

---
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the timing generator and its consumer
interface vga_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic             ce;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             fetch;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  ce,
    output hsync, vsync, de, fetch, x, y, line_start, frame_start
  );

  modport slave (
    output ce,
    input  hsync, vsync, de, fetch, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Counters and the sync/DE delay line advance only on CE; strobes are single CLK pulses.
module vga_timing_gen #(
  parameter int CNT_W    = 11,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACT    = 640,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  vga_timing_gen_if.master  vga
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_BLANK + H_ACT;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = V_BLANK + V_ACT;

  typedef logic [CNT_W-1:0] cnt_t;

  if (H_TOTAL > (1 << CNT_W)) begin : g_chk_htotal
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_chk_vtotal
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_chk_dly
    $error("vga_timing_gen: PIPE_DLY must be within 0..15");
  end

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic h_wrap, v_wrap;

  always_comb begin
    h_wrap = (h_q == cnt_t'(H_TOTAL - 1));
    v_wrap = (v_q == cnt_t'(V_TOTAL - 1));
    h_d    = h_q;
    v_d    = v_q;
    if (vga.ce) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + cnt_t'(1);
      end else begin
        h_d = h_q + cnt_t'(1);
      end
    end
  end

  // Decodes of the position the counters move to on this edge.
  logic h_act_d, v_act_d, h_sync_d, v_sync_d;
  logic fetch_d;
  cnt_t x_d, y_d;

  always_comb begin
    h_act_d  = (h_d >= cnt_t'(H_BLANK));
    v_act_d  = (v_d >= cnt_t'(V_BLANK));
    h_sync_d = (h_d >= cnt_t'(H_FP)) && (h_d < cnt_t'(H_FP + H_SYNC));
    v_sync_d = (v_d >= cnt_t'(V_FP)) && (v_d < cnt_t'(V_FP + V_SYNC));
    fetch_d  = h_act_d && v_act_d;
    x_d      = h_act_d ? (h_d - cnt_t'(H_BLANK)) : '0;
    y_d      = v_act_d ? (v_d - cnt_t'(V_BLANK)) : '0;
  end

  logic fetch_q;
  cnt_t x_q, y_q;
  logic line_start_q, frame_start_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q     <= '0;
      v_q     <= '0;
      fetch_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (vga.ce) begin
      h_q     <= h_d;
      v_q     <= v_d;
      fetch_q <= fetch_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Strobes are sampled every CLK so a CE=0 cycle clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= vga.ce && h_wrap;
      frame_start_q <= vga.ce && h_wrap && v_wrap;
    end
  end

  // Delay line holds active-high {hsync, vsync, de}; polarity is applied at the pins.
  logic [2:0] pipe_q [0:PIPE_DLY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k <= PIPE_DLY; k++) begin
        pipe_q[k] <= 3'b000;
      end
    end else if (vga.ce) begin
      pipe_q[0] <= {h_sync_d, v_sync_d, fetch_d};
      for (int k = 1; k <= PIPE_DLY; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign vga.hsync       = pipe_q[PIPE_DLY][2] ? HS_POL : ~HS_POL;
  assign vga.vsync       = pipe_q[PIPE_DLY][1] ? VS_POL : ~VS_POL;
  assign vga.de          = pipe_q[PIPE_DLY][0];
  assign vga.fetch       = fetch_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against a tick-count raster model
module tb_vga_timing_gen;

  localparam int CW    = 11;
  localparam int N_CYC = 4200;

  logic clk = 1'b0;
  logic rst;
  logic ce;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(CW)) if_a ();
  vga_timing_gen_if #(.CNT_W(CW)) if_b ();
  vga_timing_gen_if #(.CNT_W(CW)) if_c ();

  assign if_a.ce = ce;
  assign if_b.ce = ce;
  assign if_c.ce = ce;

  vga_timing_gen #(
    .CNT_W(CW), .H_FP(2), .H_SYNC(3), .H_BP(2), .H_ACT(8),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(4),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(2)
  ) u_a (.clk_i(clk), .rst_i(rst), .vga(if_a));

  vga_timing_gen #(
    .CNT_W(CW), .H_FP(2), .H_SYNC(3), .H_BP(2), .H_ACT(8),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(4),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
  ) u_b (.clk_i(clk), .rst_i(rst), .vga(if_b));

  vga_timing_gen #(.CNT_W(CW)) u_c (.clk_i(clk), .rst_i(rst), .vga(if_c));

  typedef struct {
    logic hs, vs, de, fetch, ls, fs;
    int   x, y;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int total = 0;
  int bad   = 0;

  // n = CE ticks since the last reset; adv = the edge just taken was a CE advance.
  function automatic exp_t model(int n, bit adv,
                                 int hfp, int hsy, int hbp, int hact,
                                 int vfp, int vsy, int vbp, int vact,
                                 int dly, bit hpol, bit vpol);
    exp_t e;
    int hb, ht, vb, vt, per, p, h, v, q, hq, vq;
    hb  = hfp + hsy + hbp;
    ht  = hb + hact;
    vb  = vfp + vsy + vbp;
    vt  = vb + vact;
    per = ht * vt;
    p   = n % per;
    h   = p % ht;
    v   = p / ht;
    e.x     = (h >= hb) ? h - hb : 0;
    e.y     = (v >= vb) ? v - vb : 0;
    e.fetch = (h >= hb) && (v >= vb);
    e.ls    = adv && (h == 0);
    e.fs    = adv && (p == 0);
    if (n < dly) begin
      e.hs = !hpol;
      e.vs = !vpol;
      e.de = 1'b0;
    end else begin
      q  = (n - dly) % per;
      hq = q % ht;
      vq = q / ht;
      e.hs = (hq >= hfp && hq < hfp + hsy) ? hpol : !hpol;
      e.vs = (vq >= vfp && vq < vfp + vsy) ? vpol : !vpol;
      e.de = (hq >= hb) && (vq >= vb);
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(string d, exp_t e,
                         logic hs, logic vs, logic de, logic fetch,
                         logic ls, logic fs, logic [CW-1:0] x, logic [CW-1:0] y);
    chk({d, ".hsync"},       32'(hs),    32'(e.hs));
    chk({d, ".vsync"},       32'(vs),    32'(e.vs));
    chk({d, ".de"},          32'(de),    32'(e.de));
    chk({d, ".fetch"},       32'(fetch), 32'(e.fetch));
    chk({d, ".line_start"},  32'(ls),    32'(e.ls));
    chk({d, ".frame_start"}, 32'(fs),    32'(e.fs));
    chk({d, ".x"},           32'(x),     32'(e.x));
    chk({d, ".y"},           32'(y),     32'(e.y));
  endtask

  int  n_ticks;
  bit  adv;
  int  c;

  initial begin
    rst     = 1'b1;
    ce      = 1'b1;
    n_ticks = 0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      if (rst) begin
        n_ticks = 0;
        adv     = 1'b0;
      end else if (ce) begin
        n_ticks++;
        adv = 1'b1;
      end else begin
        adv = 1'b0;
      end
      qa.push_back(model(n_ticks, adv, 2, 3, 2, 8, 1, 1, 1, 4, 2, 1'b0, 1'b0));
      qb.push_back(model(n_ticks, adv, 2, 3, 2, 8, 1, 1, 1, 4, 0, 1'b1, 1'b1));
      qc.push_back(model(n_ticks, adv, 16, 96, 48, 640, 10, 2, 33, 480, 0, 1'b0, 1'b0));
      #1;
      c = cyc + 1;
      if (c < 2) begin
        rst = 1'b1; ce = 1'b1;
      end else if (c < 1800) begin
        rst = 1'b0; ce = 1'b1;
      end else if (c < 2100) begin
        rst = 1'b0; ce = (c % 2 == 0);
      end else if (c == 2100) begin
        rst = 1'b1; ce = 1'b1;
      end else if (c < 3000) begin
        rst = 1'b0; ce = 1'b1;
      end else begin
        rst = ($urandom_range(0, 199) == 0);
        ce  = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    exp_t ea, eb, ec;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty actual=0 expected=1 at t=%0t", $time);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        ec = qc.pop_front();
        cmp_dut("a", ea, if_a.hsync, if_a.vsync, if_a.de, if_a.fetch,
                if_a.line_start, if_a.frame_start, if_a.x, if_a.y);
        cmp_dut("b", eb, if_b.hsync, if_b.vsync, if_b.de, if_b.fetch,
                if_b.line_start, if_b.frame_start, if_b.x, if_b.y);
        cmp_dut("c", ec, if_c.hsync, if_c.vsync, if_c.de, if_c.fetch,
                if_c.line_start, if_c.frame_start, if_c.x, if_c.y);
      end
    end
  end

endmodule
